// File: rtl/flit_packer.sv
// FlitZip packer: finds the narrowest common signed chunk width and packs chunks left-aligned.
// Optional FLITPACK_STATS_EN adds transfer and saved-bit counters.
module flit_packer #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned CHUNK_SIZE = 8,
   parameter int unsigned EN_BITS    = 3,
   parameter int unsigned LEN_BITS   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [EN_BITS-1:0]    out_en,
   output logic [LEN_BITS-1:0]   comp_len
`ifdef FLITPACK_STATS_EN
   ,
   output logic [31:0]           stat_flits,
   output logic [31:0]           stat_saved
`endif
);

   localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_SIZE;
   localparam int unsigned NUM_WIDTHS = 1 << EN_BITS;

   logic                  adv1;
   logic                  adv2;
   logic                  s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_data_q;
   logic [EN_BITS-1:0]    s1_en_q;
   logic [EN_BITS-1:0]    en_d;
   logic [EN_BITS-1:0]    chunk_en;
   logic [LEN_BITS-1:0]   len_d;
   logic [DATA_WIDTH-1:0] cand [NUM_WIDTHS];

   // out_valid is the stage-2 valid flag.
   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1;

   // Per chunk, en = index of the highest bit differing from the sign bit (+1), else 0.
   always_comb begin
      en_d     = '0;
      chunk_en = '0;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         chunk_en = '0;
         for (int i = 0; i < CHUNK_SIZE - 1; i++) begin
            if (in_data[k*CHUNK_SIZE+i] != in_data[k*CHUNK_SIZE+CHUNK_SIZE-1]) begin
               chunk_en = EN_BITS'(i + 1);
            end
         end
         if (chunk_en > en_d) begin
            en_d = chunk_en;
         end
      end
   end

   // One fixed packing per candidate width; stage 2 selects by the stage-1 width.
   always_comb begin
      for (int n = 1; n <= NUM_WIDTHS; n++) begin
         cand[n-1] = '0;
         for (int k = 0; k < NUM_CHUNKS; k++) begin
            for (int b = 0; b < n; b++) begin
               cand[n-1][DATA_WIDTH-(NUM_CHUNKS-k)*n+b] = s1_data_q[k*CHUNK_SIZE+b];
            end
         end
      end
   end

   assign len_d = LEN_BITS'(NUM_CHUNKS * (32'(s1_en_q) + 32'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_en_q    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_en     <= '0;
         comp_len   <= '0;
      end else begin
         if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_data_q <= in_data;
               s1_en_q   <= en_d;
            end
         end
         if (adv2) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
               out_data <= cand[s1_en_q];
               out_en   <= s1_en_q;
               comp_len <= len_d;
            end
         end
      end
   end

`ifdef FLITPACK_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_flits <= '0;
         stat_saved <= '0;
      end else if (out_valid && out_ready) begin
         stat_flits <= stat_flits + 32'd1;
         stat_saved <= stat_saved + (32'(DATA_WIDTH) - 32'(comp_len));
      end
   end
`endif

endmodule
